// File: rtl/wb_stage.sv
// Write-back stage: commits ALU results directly and loads after memory acknowledge, with extraction.
// Latency: ALU 1 cycle; load 1 cycle to request, then 1 cycle after mem_ack (timeout aborts after TIMEOUT cycles).
// Backpressure: ex_ready low while a load is outstanding; one load in flight at most.
module wb_stage #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_result,
    input  logic        ex_is_load,
    input  logic [2:0]  ex_funct3,
    input  logic [1:0]  ex_addr_lo,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] WB_out,
    output logic        RegBank_en,
    output logic [4:0]  WB_rd,
    output logic        stall,
    output logic        load_err
);

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, COMMIT} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lo_q, lo_d;

    logic        ex_ready_q, ex_ready_d;
    logic        mem_req_q, mem_req_d;
    logic        stall_q, stall_d;
    logic [31:0] wb_out_q, wb_out_d;
    logic        reg_en_q, reg_en_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        load_err_q, load_err_d;

    logic        accept;
    logic        load_ok;
    logic        timeout_hit;

    // Width/alignment legality of a load: bytes any lane, halves even lanes, words lane 0.
    function automatic logic legal_load(input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        case (f3)
            3'd0, 3'd4: ok = 1'b1;
            3'd1, 3'd5: ok = ~lo[0];
            3'd2:       ok = (lo == 2'd0);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Pick the addressed byte/half out of the aligned word and extend it.
    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = lo[1] ? d[31:16] : d[15:0];
        case (f3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd4:    r = {24'h0, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd5:    r = {16'h0, h};
            default: r = d;
        endcase
        return r;
    endfunction

    assign accept      = ex_valid && ex_ready_q;
    assign load_ok     = legal_load(ex_funct3, ex_addr_lo);
    assign timeout_hit = (cnt_q == LAST_WAIT);

    // State register plus capture and output flops; reset drops everything but ex_ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            rd_q       <= 5'd0;
            f3_q       <= 3'd0;
            lo_q       <= 2'd0;
            ex_ready_q <= 1'b1;
            mem_req_q  <= 1'b0;
            stall_q    <= 1'b0;
            wb_out_q   <= 32'd0;
            reg_en_q   <= 1'b0;
            wb_rd_q    <= 5'd0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            f3_q       <= f3_d;
            lo_q       <= lo_d;
            ex_ready_q <= ex_ready_d;
            mem_req_q  <= mem_req_d;
            stall_q    <= stall_d;
            wb_out_q   <= wb_out_d;
            reg_en_q   <= reg_en_d;
            wb_rd_q    <= wb_rd_d;
            load_err_q <= load_err_d;
        end
    end

    // Next state: accept in IDLE/COMMIT, leave LOAD_WAIT on ack or on the last timed-out cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, COMMIT: begin
                if (accept && !ex_is_load)  state_d = COMMIT;
                else if (accept && load_ok) state_d = LOAD_WAIT;
                else                        state_d = IDLE;
            end
            LOAD_WAIT: begin
                if (mem_ack)          state_d = COMMIT;
                else if (timeout_hit) state_d = IDLE;
                else                  state_d = LOAD_WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next output/capture values; status outputs follow the next state so they stay registered.
    always_comb begin
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        f3_d       = f3_q;
        lo_d       = lo_q;
        wb_out_d   = wb_out_q;
        wb_rd_d    = wb_rd_q;
        reg_en_d   = 1'b0;
        load_err_d = 1'b0;
        mem_req_d  = (state_d == LOAD_WAIT);
        stall_d    = (state_d == LOAD_WAIT);
        ex_ready_d = (state_d != LOAD_WAIT);
        case (state_q)
            IDLE, COMMIT: begin
                if (accept) begin
                    if (!ex_is_load) begin
                        wb_out_d = ex_result;
                        wb_rd_d  = ex_rd;
                        reg_en_d = (ex_rd != 5'd0);
                    end else if (load_ok) begin
                        rd_d  = ex_rd;
                        f3_d  = ex_funct3;
                        lo_d  = ex_addr_lo;
                        cnt_d = 8'd0;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end
            end
            LOAD_WAIT: begin
                if (mem_ack) begin
                    wb_out_d = extract(f3_q, lo_q, mem_rdata);
                    wb_rd_d  = rd_q;
                    reg_en_d = (rd_q != 5'd0);
                end else if (timeout_hit) begin
                    load_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign ex_ready   = ex_ready_q;
    assign mem_req    = mem_req_q;
    assign stall      = stall_q;
    assign WB_out     = wb_out_q;
    assign RegBank_en = reg_en_q;
    assign WB_rd      = wb_rd_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic        ex_is_load;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_addr_lo;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] WB_out;
    logic        RegBank_en;
    logic [4:0]  WB_rd;
    logic        stall;
    logic        load_err;

    wb_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_result(ex_result),
        .ex_is_load(ex_is_load), .ex_funct3(ex_funct3), .ex_addr_lo(ex_addr_lo),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .WB_out(WB_out), .RegBank_en(RegBank_en), .WB_rd(WB_rd),
        .stall(stall), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [4:0]  rd;
        logic [31:0] dat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference load extraction: shift the addressed lane down, then extend.
    function automatic logic [31:0] ld_ref(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] d);
        logic [31:0] s;
        s = d >> (lo * 8);
        case (f3)
            3'd0:    return {{24{s[7]}}, s[7:0]};
            3'd4:    return {24'h0, s[7:0]};
            3'd1:    return {{16{s[15]}}, s[15:0]};
            3'd5:    return {16'h0, s[15:0]};
            default: return d;
        endcase
    endfunction

    // Scoreboard: every write or error pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset && (RegBank_en || load_err)) begin
            if (sb.size() == 0) begin
                check("unexp_out", {30'd0, RegBank_en, load_err}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("err", {31'd0, load_err}, {31'd0, e.err});
                check("wen", {31'd0, RegBank_en}, {31'd0, ~e.err});
                if (!e.err) begin
                    check("wb_rd", {27'd0, WB_rd}, {27'd0, e.rd});
                    check("wb_out", WB_out, e.dat);
                end
            end
        end
    end

    task automatic alu(input logic [4:0] rd, input logic [31:0] res);
        exp_t e;
        check("ready_alu", {31'd0, ex_ready}, 32'd1);
        ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = rd; ex_result = res;
        ex_funct3 = 3'd2; ex_addr_lo = 2'd1;
        if (rd != 5'd0) begin
            e.err = 1'b0; e.rd = rd; e.dat = res;
            sb.push_back(e);
        end
        @(negedge clk);
        ex_valid = 1'b0;
        check("wen_alu", {31'd0, RegBank_en}, {31'd0, rd != 5'd0});
        check("ready_after", {31'd0, ex_ready}, 32'd1);
        @(negedge clk);
        check("wen_drop", {31'd0, RegBank_en}, 32'd0);
    endtask

    // ack_at: LOAD_WAIT cycle number carrying mem_ack (0 = never); exp_n: expected mem_req cycles.
    task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                        input logic [31:0] rdata, input int ack_at, input int exp_n);
        exp_t e;
        int   n;
        check("ready_ld", {31'd0, ex_ready}, 32'd1);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = rd; ex_funct3 = f3; ex_addr_lo = lo;
        ex_result = 32'h5555AAAA;
        if (exp_n == 0 || ack_at == 0) begin
            e.err = 1'b1; e.rd = 5'd0; e.dat = 32'd0;
            sb.push_back(e);
        end else if (rd != 5'd0) begin
            e.err = 1'b0; e.rd = rd; e.dat = ld_ref(f3, lo, rdata);
            sb.push_back(e);
        end
        @(negedge clk);
        ex_valid = 1'b0; ex_is_load = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (!mem_req) break;
            n++;
            check("stall_hi", {31'd0, stall}, 32'd1);
            mem_ack   = (n == ack_at);
            mem_rdata = (n == ack_at) ? rdata : $urandom;
            @(negedge clk);
            mem_ack = 1'b0;
        end
        check("req_cycles", n, exp_n);
        check("stall_lo", {31'd0, stall}, 32'd0);
        check("ready_back", {31'd0, ex_ready}, 32'd1);
        @(negedge clk);
        check("quiet", {30'd0, RegBank_en, load_err}, 32'd0);
    endtask

    initial begin
        logic [2:0] f3;
        logic [1:0] lo;
        int         d;
        reset = 1'b0; ex_valid = 1'b0; ex_rd = 5'd0; ex_result = 32'd0; ex_is_load = 1'b0;
        ex_funct3 = 3'd0; ex_addr_lo = 2'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        #12;
        check("rst_ready", {31'd0, ex_ready}, 32'd1);
        check("rst_outs", {27'd0, mem_req, stall, RegBank_en, load_err, 1'b0}, 32'd0);
        check("rst_wb", WB_out, 32'd0);
        check("rst_rd", {27'd0, WB_rd}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        alu(5'd5, 32'hDEADBEEF);
        load(5'd7, 3'd0, 2'd3, 32'h80123456, 3, 3);
        load(5'd7, 3'd4, 2'd3, 32'h80123456, 3, 3);
        load(5'd8, 3'd1, 2'd2, 32'h80017FFF, 1, 1);
        load(5'd9, 3'd2, 2'd1, 32'h11111111, 1, 0);
        load(5'd9, 3'd3, 2'd0, 32'h11111111, 1, 0);
        load(5'd9, 3'd5, 2'd1, 32'h11111111, 1, 0);
        load(5'd10, 3'd2, 2'd0, 32'hCAFEF00D, 0, TO);
        load(5'd11, 3'd2, 2'd0, 32'hCAFEF00D, TO, TO);
        load(5'd0, 3'd2, 2'd0, 32'h12345678, 2, 2);
        alu(5'd0, 32'h00001234);

        // back-to-back ALU ops produce consecutive write pulses
        for (int i = 1; i <= 3; i++) begin
            exp_t e;
            ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = 5'(i); ex_result = 32'h100 + 32'(i);
            e.err = 1'b0; e.rd = 5'(i); e.dat = 32'h100 + 32'(i);
            sb.push_back(e);
            @(negedge clk);
            check("b2b_wen", {31'd0, RegBank_en}, 32'd1);
            check("b2b_ready", {31'd0, ex_ready}, 32'd1);
        end
        ex_valid = 1'b0;
        @(negedge clk);
        check("b2b_drop", {31'd0, RegBank_en}, 32'd0);

        // a few random legal loads
        for (int k = 0; k < 6; k++) begin
            case ($urandom_range(0, 4))
                0: begin f3 = 3'd0; lo = 2'($urandom_range(0, 3)); end
                1: begin f3 = 3'd4; lo = 2'($urandom_range(0, 3)); end
                2: begin f3 = 3'd1; lo = {1'($urandom_range(0, 1)), 1'b0}; end
                3: begin f3 = 3'd5; lo = {1'($urandom_range(0, 1)), 1'b0}; end
                default: begin f3 = 3'd2; lo = 2'd0; end
            endcase
            d = $urandom_range(1, 5);
            load(5'($urandom_range(1, 31)), f3, lo, $urandom, d, d);
        end

        // reset in the middle of a load
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd12; ex_funct3 = 3'd2; ex_addr_lo = 2'd0;
        @(negedge clk);
        ex_valid = 1'b0; ex_is_load = 1'b0;
        check("mid_req", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_req", {31'd0, mem_req}, 32'd0);
        check("arst_stall", {31'd0, stall}, 32'd0);
        check("arst_wen", {31'd0, RegBank_en}, 32'd0);
        check("arst_ready", {31'd0, ex_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_ack_wen", {31'd0, RegBank_en}, 32'd0);
        check("late_ack_req", {31'd0, mem_req}, 32'd0);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage: sole producer of WB_out, RegBank_en and the destination register index consumed by the ID-stage register bank write port.
- Accepts one retired instruction per handshake from the execute side.
- ALU results commit directly. Loads issue a data-memory request, wait for the acknowledge, then align, sign- or zero-extend and commit.
- Also provides a stall signal to upstream stages and a load-error pulse.

Parameters:
TIMEOUT, 15, max cycles in LOAD_WAIT without mem_ack before the load is aborted (1..255)

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
ex_valid  input  1  execute side presents an instruction
ex_ready  output  1  stage can accept; transfer when ex_valid && ex_ready
ex_rd  input  5  destination register index
ex_result  input  32  ALU result (non-load)
ex_is_load  input  1  instruction is a load (opcode 0000011)
ex_funct3  input  3  load width/sign: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu
ex_addr_lo  input  2  effective address bits [1:0]
mem_req  output  1  data-memory read request, held until mem_ack
mem_ack  input  1  read data valid this cycle
mem_rdata  input  32  word-aligned read data
WB_out  output  32  value written to register bank
RegBank_en  output  1  register bank write enable, 1-cycle pulse
WB_rd  output  5  write destination, valid with RegBank_en
stall  output  1  high while a load is outstanding
load_err  output  1  1-cycle pulse: misaligned, illegal funct3, or timeout

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0, except ex_ready=1.
  - Timeout counter 0.
  - Captured fields cleared.
  - Reset mid-load drops mem_req immediately; no commit follows.
- All outputs are registered.
- FSM states: IDLE, LOAD_WAIT, COMMIT.
- ex_ready:
  - 1 in IDLE and COMMIT.
  - 0 in LOAD_WAIT.
  - Back-to-back acceptance while in COMMIT is allowed.
- Transfer when not a load:
  - Next cycle: state=COMMIT, WB_out=ex_result, WB_rd=ex_rd, RegBank_en=(ex_rd!=0).
  - Latency 1 cycle.
- Transfer when a load with legal funct3 and alignment:
  - Next cycle: state=LOAD_WAIT, mem_req=1, stall=1.
  - Capture rd, funct3 and addr_lo; counter=0.
- Legality:
  - lw requires addr_lo=0.
  - lh/lhu require addr_lo[0]=0.
  - funct3 in {3,6,7} is illegal.
- Illegal or misaligned load:
  - Next cycle: load_err=1, RegBank_en=0, no mem_req, state=IDLE (or COMMIT/LOAD_WAIT if a new instruction is accepted).
- LOAD_WAIT:
  - mem_req is held at 1 until mem_ack.
  - On mem_ack: the cycle after, mem_req=0 and stall=0, state=COMMIT, RegBank_en=(rd!=0), WB_out=extracted data.
  - mem_ack outside LOAD_WAIT is ignored.
- Extraction (lane = addr_lo):
  - lb: byte[8*lane+7:8*lane], sign-extended to 32 bits.
  - lbu: same byte, zero-extended.
  - lh: half[16*addr_lo[1]+15:16*addr_lo[1]], sign-extended.
  - lhu: same half, zero-extended.
  - lw: mem_rdata unchanged.
- Timeout:
  - Counter increments each LOAD_WAIT cycle without ack.
  - When counter reaches TIMEOUT-1 with no ack: next cycle mem_req=0, stall=0, load_err=1, RegBank_en=0, state=IDLE.
  - mem_ack arriving in that same last cycle wins: commit occurs, no error.
- COMMIT:
  - RegBank_en is a single-cycle pulse.
  - Without a new transfer, the next cycle is IDLE with RegBank_en=0.
  - WB_out and WB_rd hold their last values (don't-care while RegBank_en=0).
- rd=0: the handshake and memory request complete normally; only RegBank_en is suppressed.
- Never more than one load outstanding. stall equals (state==LOAD_WAIT).

Test Plan:
- Reset deasserted; ALU op rd=5, result 0xDEADBEEF, ex_valid=1 one cycle → next cycle RegBank_en=1, WB_rd=5, WB_out=0xDEADBEEF; following cycle RegBank_en=0.
- lb rd=7, addr_lo=3; mem_ack after 2 wait cycles with rdata 0x80123456 → mem_req high 3 cycles, then WB_out=0xFFFFFF80, RegBank_en=1, WB_rd=7; same with lbu → 0x00000080.
- lh addr_lo=2, rdata 0x8001_7FFF → WB_out=0xFFFF8001; lw addr_lo=1 → load_err pulse, no mem_req, no write.
- Load with mem_ack never asserted, TIMEOUT=15 → mem_req high exactly 15 cycles, then load_err=1 and stall=0; no RegBank_en. Repeat with ack on the 15th cycle → commit, no error.
- ALU op rd=0 result 0x1234 → RegBank_en stays 0, ex_ready stays 1; three back-to-back ALU ops rd=1,2,3 → three consecutive RegBank_en pulses.
- Assert reset=0 during LOAD_WAIT → mem_req, stall and RegBank_en drop asynchronously; after release, a late mem_ack causes no write.
